div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Shares one shift-and-subtract fraction divider between NREQ requesters.
- Each request carries a 7-bit dividend and a 7-bit divisor. The block arbitrates round-robin, loads the divider, and sequences its 8 iterations.
- It returns a floor-rounded Q0.8 quotient, tagged with the requester ID, on a valid/ready response port.
- Sits between the per-pixel ratio producers and the interpolation stage.

Parameters:
- NREQ, 4, number of requesters (2..8).
- OPW, 7, operand width of dividend and divisor.
- FRW, 8, fraction width; equals the number of iterations.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_dividend  in  NREQ*OPW  packed; slot i at [i*OPW +: OPW].
- req_divisor  in  NREQ*OPW  packed, same layout.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  clog2(NREQ)  index of the requester that owns the result.
- rsp_frac  out  FRW  floor(dividend*2^FRW/divisor), Q0.8.
- rsp_err  out  1  divisor==0 or dividend>=divisor; rsp_frac=8'hFF.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_frac=0, rsp_id=0, rsp_err=0, busy=0, iteration counter=0, remainder=0, quotient=0. The round-robin pointer resets to NREQ-1, so requester 0 wins first.
- Accept window: the state is IDLE, or the state is DONE and rsp_ready=1 in the same cycle.
- Grant: the first set req_valid bit searching upward, with wrap, from pointer+1.
- req_ready is combinational. Only the granted bit is high, and only inside the accept window. It must never depend on req_valid of other slots beyond the grant search.
- Handshake = req_valid[g] & req_ready[g]. On the handshake edge:
  - latch rsp_id=g, the divisor and the error flag;
  - load remainder=dividend and quotient=0;
  - counter=0;
  - pointer=g.
- Error path, taken when divisor==0 or dividend>=divisor:
  - the next state is DONE directly, with rsp_frac=8'hFF and rsp_err=1;
  - rsp_valid is high on the cycle after the handshake.
- Normal path, the next state is RUN. Each RUN edge performs one iteration:
  - shifted = remainder<<1, in 8 bits;
  - ge = shifted >= {0,divisor};
  - remainder = ge ? shifted-divisor : shifted;
  - quotient = {quotient[6:0], ge};
  - counter increments.
- The edge that ends counter==FRW-1 moves the state to DONE and copies quotient into rsp_frac. rsp_err=0.
- Latency: the handshake happens in cycle 0; RUN covers cycles 1..8; rsp_valid is high in cycle 9.
- DONE: rsp_valid=1. rsp_frac, rsp_id and rsp_err are stable until rsp_ready.
  - On rsp_ready with no new handshake, the state moves to IDLE and rsp_valid drops next cycle.
  - On rsp_ready with a new handshake in the same cycle, the state moves to RUN (or back to DONE on the error path). The response fields update on the next edge.
- Peak throughput is one result per 9 cycles. rsp_ready is ignored outside DONE.
- Requesters must hold valid and operands until ready. A requester that drops valid without a handshake is simply not granted.
- Reset asserted mid-RUN or mid-DONE aborts the operation with no response; all registers return to their reset values.
- Arithmetic: remainder is 8-bit unsigned. The dividend<divisor precondition (enforced by the error path) keeps remainder < divisor, so no overflow.

Decomposition:
- Shared package div_sched_pkg holds:
  - the state encoding constants IDLE, RUN, DONE;
  - the FRW iteration-count constant;
  - the constant 8'hFF for the error fraction.
- One sub-module: frac_div_core. It holds the remainder, quotient and one-iteration datapath, with load and step enables.
- div_sched contains the FSM, counter, round-robin arbiter and response registers.

Test Plan:
- Single request, slot 0: dividend=1, divisor=3 -> rsp_valid 9 cycles after handshake, rsp_frac=8'h55, rsp_id=0, rsp_err=0.
- Boundary values: 5/7 -> 8'hB6; 63/127 -> 8'h7E; 0/9 -> 8'h00.
- Error cases: divisor=0 -> rsp_valid the cycle after handshake, rsp_frac=8'hFF, rsp_err=1. Dividend=9, divisor=9 gives the same response.
- All four slots valid continuously, rsp_ready=1:
  - grants in order 0,1,2,3,0;
  - results back-to-back, 9 cycles apart;
  - never two req_ready bits set in the same cycle.
- Backpressure: rsp_ready=0 for 20 cycles in DONE -> outputs stable, req_ready all 0. Raise rsp_ready -> the same-cycle handshake for the next pending slot occurs.
- Reset pulse (async, mid-clock) at RUN counter=4 -> busy=0 and rsp_valid=0 immediately. The pointer resets, so slot 0 wins next.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared constants for the divider scheduler: FSM encoding, iteration count,
// and the saturated fraction returned on the error path.
package div_sched_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // One quotient bit is produced per iteration.
    localparam int ITERS = 8;

    // Fraction reported when the quotient is not representable in Q0.8.
    localparam logic [7:0] ERR_FRAC = 8'hFF;
endpackage

// File: rtl/div_sched_frac_div_core.sv
// Restoring shift-and-subtract fraction divider datapath: one quotient bit
// per step. Precondition dividend < divisor keeps remainder < divisor.
module frac_div_core #(
    parameter int OPW = 7,
    parameter int FRW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [OPW-1:0] dividend,
    input  logic [OPW-1:0] divisor,
    output logic [FRW-1:0] quotient,
    output logic [FRW-1:0] quotient_next
);
    logic [OPW:0] remainder;
    logic [OPW:0] shifted;
    logic         ge;

    // One iteration: double the remainder and try to subtract the divisor.
    always_comb begin
        shifted       = remainder << 1;
        ge            = shifted >= {1'b0, divisor};
        quotient_next = {quotient[FRW-2:0], ge};
    end

    // Remainder/quotient state: load clears the quotient, step shifts in a bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remainder <= '0;
            quotient  <= '0;
        end else if (load) begin
            remainder <= {1'b0, dividend};
            quotient  <= '0;
        end else if (step) begin
            remainder <= ge ? (shifted - {1'b0, divisor}) : shifted;
            quotient  <= quotient_next;
        end
    end
endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one fraction divider between NREQ requesters.
// Returns floor(dividend*2^FRW/divisor) tagged with the requester index.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int OPW  = 7,
    parameter int FRW  = ITERS,
    localparam int IDW = $clog2(NREQ),
    localparam int CW  = $clog2(FRW)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_dividend,
    input  logic [NREQ*OPW-1:0] req_divisor,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [FRW-1:0]      rsp_frac,
    output logic                rsp_err,
    output logic                busy
);
    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  cnt;
    logic [OPW-1:0] div_q;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] idx;
    logic           found;
    logic           window;
    logic           hs;
    logic           hs_err;
    logic [OPW-1:0] sel_a;
    logic [OPW-1:0] sel_b;
    logic [FRW-1:0] quotient;
    logic [FRW-1:0] quotient_next;

    // Round-robin search upward from ptr+1 with wrap; first valid slot wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    // Accept window and operand selection for the granted slot.
    always_comb begin
        window    = (state == IDLE) || (state == DONE && rsp_ready);
        hs        = window && found;
        req_ready = '0;
        if (hs) req_ready[gnt] = 1'b1;
        sel_a     = req_dividend[gnt*OPW +: OPW];
        sel_b     = req_divisor[gnt*OPW +: OPW];
        hs_err    = (sel_b == '0) || (sel_a >= sel_b);
    end

    // FSM, iteration counter, arbiter pointer and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= IDW'(NREQ - 1);
            cnt      <= '0;
            div_q    <= '0;
            rsp_id   <= '0;
            rsp_frac <= '0;
            rsp_err  <= 1'b0;
        end else if (hs) begin
            rsp_id  <= gnt;
            div_q   <= sel_b;
            ptr     <= gnt;
            cnt     <= '0;
            rsp_err <= hs_err;
            if (hs_err) begin
                state    <= DONE;
                rsp_frac <= FRW'(ERR_FRAC);
            end else begin
                state <= RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(FRW - 1)) begin
                        state    <= DONE;
                        rsp_frac <= quotient_next;
                        rsp_err  <= 1'b0;
                    end
                end
                DONE:    if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    frac_div_core #(.OPW(OPW), .FRW(FRW)) u_core (
        .clk          (clk),
        .rst          (rst),
        .load         (hs),
        .step         (state == RUN),
        .dividend     (sel_a),
        .divisor      (hs ? sel_b : div_q),
        .quotient     (quotient),
        .quotient_next(quotient_next)
    );
endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: random requesters and response
// backpressure checked every cycle against a transaction-level model.
module tb_div_sched;
    localparam int NREQ = 4;
    localparam int OPW  = 7;
    localparam int FRW  = 8;
    localparam int IDW  = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_dividend;
    logic [NREQ*OPW-1:0] req_divisor;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [FRW-1:0]      rsp_frac;
    logic                rsp_err;
    logic                busy;

    div_sched #(.NREQ(NREQ), .OPW(OPW), .FRW(FRW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dividend(req_dividend),
        .req_divisor (req_divisor),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_frac    (rsp_frac),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected responses in issue order; t is the cycle rsp_valid must rise.
    typedef struct {
        int id;
        int frac;
        int err;
        int t;
    } rsp_t;
    rsp_t q[$];

    int ptr = NREQ - 1;
    int cyc = 0;
    bit v[NREQ];
    int a[NREQ];
    int b[NREQ];
    int p_req = 0;
    int p_rdy = 100;
    int bp_left = 0;
    bit err_ok = 0;

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]               = v[i];
            req_dividend[i*OPW +: OPW] = a[i][OPW-1:0];
            req_divisor[i*OPW +: OPW]  = b[i][OPW-1:0];
        end
    endtask

    function automatic void new_op(input int s);
        int sel;
        sel = err_ok ? int'($urandom_range(0, 5)) : 5;
        if (sel == 0) begin
            b[s] = 0;
            a[s] = $urandom_range(0, 127);
        end else if (sel == 1) begin
            b[s] = $urandom_range(1, 127);
            a[s] = $urandom_range(b[s], 127);
        end else begin
            b[s] = $urandom_range(1, 127);
            a[s] = $urandom_range(0, b[s] - 1);
        end
    endfunction

    // One clock of checking and stimulus; entered and left at posedge+1.
    task automatic step();
        int g;
        bit any;
        bit wv;
        bit win;
        int acc;
        logic [NREQ-1:0] er;
        rsp_t r;
        acc = -1;
        @(negedge clk);
        any = 0;
        g   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any && v[(ptr + k) % NREQ]) begin
                any = 1;
                g   = (ptr + k) % NREQ;
            end
        end
        wv  = (q.size() > 0) && (cyc >= q[0].t);
        win = (q.size() == 0) || (wv && rsp_ready);
        er  = '0;
        if (win && any) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(wv));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        if (wv) begin
            chk("rsp_id", 32'(rsp_id), q[0].id);
            chk("rsp_frac", 32'(rsp_frac), q[0].frac);
            chk("rsp_err", 32'(rsp_err), q[0].err);
        end
        if (wv && rsp_ready) void'(q.pop_front());
        if (win && any) begin
            r.id   = g;
            r.err  = (b[g] == 0 || a[g] >= b[g]) ? 1 : 0;
            r.frac = r.err ? 255 : (a[g] * 256) / b[g];
            r.t    = cyc + (r.err ? 1 : 9);
            q.push_back(r);
            ptr = g;
            acc = g;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc >= 0) v[acc] = 0;
        for (int s = 0; s < NREQ; s++) begin
            if (!v[s] && int'($urandom_range(0, 99)) < p_req) begin
                new_op(s);
                v[s] = 1;
            end
        end
        if (bp_left > 0) begin
            rsp_ready = 1'b0;
            if (wv) bp_left--;
        end else begin
            rsp_ready = int'($urandom_range(0, 99)) < p_rdy;
        end
        drive();
    endtask

    task automatic single(input int s, input int x, input int y);
        a[s] = x;
        b[s] = y;
        v[s] = 1;
        drive();
        repeat (12) step();
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 0;
            a[i] = 0;
            b[i] = 1;
        end
        rsp_ready = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_frac", 32'(rsp_frac), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Directed values, including both error forms.
        single(0, 1, 3);
        single(1, 5, 7);
        single(2, 63, 127);
        single(3, 0, 9);
        single(0, 5, 0);
        single(1, 9, 9);

        // Random traffic with errors and random response backpressure.
        err_ok = 1;
        p_req  = 30;
        p_rdy  = 60;
        repeat (300) step();
        p_req = 0;
        p_rdy = 100;
        repeat (50) step();

        // Abort mid-RUN at counter 4; outputs clear without waiting for a clock.
        single(2, 5, 7);
        a[2] = 5;
        b[2] = 7;
        v[2] = 1;
        drive();
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        q.delete();
        ptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) v[i] = 0;
        drive();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        cyc++;

        // All slots continuously valid: strict rotation, one result per 9 cycles.
        err_ok = 0;
        p_req  = 100;
        for (int i = 0; i < NREQ; i++) begin
            new_op(i);
            v[i] = 1;
        end
        rsp_ready = 1'b1;
        drive();
        repeat (60) step();

        // Hold the response 20 cycles in DONE, then release.
        bp_left = 20;
        repeat (60) step();

        p_req = 0;
        repeat (50) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
